// File: rtl/layer1_result_streamer_pkg.sv
// Shared layer-1/layer-2 interface defaults and the streamer state encoding.
// The layer-1 engine and the layer-2 loader use the same defaults.
package layer1_result_streamer_pkg;

    localparam int DEF_ACC_WIDTH = 32;
    localparam int DEF_NUM_PES   = 32;
    localparam int DEF_OUT_WIDTH = 8;
    localparam int DEF_SHIFT     = 7;
    localparam int DEF_IDX_W     = 5;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_ARM    = 2'b01,
        S_STREAM = 2'b10
    } state_t;

endpackage

// File: rtl/layer1_result_streamer_requant_sat.sv
// Combinational requantizer: arithmetic right shift, then clamp to [0, 2^(OUT_WIDTH-1)-1].
// Kept standalone so later layers can reuse it with their own widths.
module requant_sat #(
    parameter int ACC_WIDTH = 32,
    parameter int OUT_WIDTH = 8,
    parameter int SHIFT     = 7
) (
    input  logic signed [ACC_WIDTH-1:0] acc,
    output logic        [OUT_WIDTH-1:0] act
);

    localparam logic signed [ACC_WIDTH-1:0] MAX_ACT = ACC_WIDTH'((1 << (OUT_WIDTH - 1)) - 1);

    logic signed [ACC_WIDTH-1:0] shifted;

    always_comb begin
        shifted = acc >>> SHIFT;
        if (shifted[ACC_WIDTH-1]) begin
            act = '0;
        end else if (shifted > MAX_ACT) begin
            act = MAX_ACT[OUT_WIDTH-1:0];
        end else begin
            act = shifted[OUT_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/layer1_result_streamer.sv
// Captures the layer-1 result vector and streams requantized activations to layer 2.
//   state    | meaning
//   S_IDLE   | waiting for done_in; no stream word presented
//   S_ARM    | layer 1 is writing results this cycle; buffer loads on the exit edge
//   S_STREAM | presenting buffer[idx] on the valid/ready stream
module layer1_result_streamer
    import layer1_result_streamer_pkg::*;
#(
    parameter int ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int NUM_PES   = DEF_NUM_PES,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH,
    parameter int SHIFT     = DEF_SHIFT,
    parameter int IDX_W     = DEF_IDX_W
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         done_in,
    input  logic [ACC_WIDTH*NUM_PES-1:0] result_vector,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [OUT_WIDTH-1:0]         m_data,
    output logic [IDX_W-1:0]             m_index,
    output logic                         m_last,
    output logic                         frame_done,
    output logic                         overrun
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PES - 1);

    state_t               state;
    state_t               state_nxt;
    logic [IDX_W-1:0]     idx;
    logic [ACC_WIDTH-1:0] buffer [NUM_PES];
    logic [OUT_WIDTH-1:0] act;
    logic                 fire;
    logic                 at_last;

    assign m_valid = (state == S_STREAM);
    assign at_last = (idx == LAST_IDX);
    assign fire    = m_valid && m_ready;
    assign m_last  = m_valid && at_last;
    assign m_index = idx;
    // Gate the mux so m_data reads 0 whenever no word is presented.
    assign m_data  = m_valid ? act : '0;

    requant_sat #(
        .ACC_WIDTH (ACC_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .SHIFT     (SHIFT)
    ) u_requant (
        .acc (buffer[idx]),
        .act (act)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (done_in) state_nxt = S_ARM;
            S_ARM:    state_nxt = S_STREAM;
            S_STREAM: if (fire && at_last) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx        <= '0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_done <= fire && at_last;
            if (done_in && (state != S_IDLE)) begin
                overrun <= 1'b1;
            end
            if (state == S_ARM) begin
                idx <= '0;
            end else if (fire) begin
                idx <= at_last ? '0 : idx + IDX_W'(1);
            end
        end
    end

    // Layer 1 updates its results on the edge that ends done, so load on the ARM exit edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_PES; k++) begin
                buffer[k] <= '0;
            end
        end else if (state == S_ARM) begin
            for (int k = 0; k < NUM_PES; k++) begin
                buffer[k] <= result_vector[k*ACC_WIDTH +: ACC_WIDTH];
            end
        end
    end

endmodule
